// File: rtl/servo_pkg.sv
// Shared constants and types for the servo UART command parser.
package servo_pkg;

    // ASCII framing characters
    localparam logic [7:0] ASCII_HASH = 8'h23;
    localparam logic [7:0] ASCII_P    = 8'h50;
    localparam logic [7:0] ASCII_T    = 8'h54;
    localparam logic [7:0] ASCII_BANG = 8'h21;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_9    = 8'h39;

    // Error causes reported on err_code
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_SYNTAX  = 2'd1;
    localparam logic [1:0] ERR_RANGE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Number of digits in each frame field
    localparam int unsigned ID_LEN   = 3;
    localparam int unsigned PWM_LEN  = 4;
    localparam int unsigned TIME_LEN = 4;

    // Accumulator width: four decimal digits (0..9999)
    localparam int unsigned ACC_W = 14;

    typedef enum logic [2:0] {
        StHunt,
        StId,
        StSepP,
        StPwm,
        StSepT,
        StTime,
        StEnd
    } parser_state_e;

    function automatic logic is_ascii_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/servo_dec_acc.sv
// Decimal digit detector and shared acc*10+d accumulator.
module servo_dec_acc
    import servo_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       data,
    input  logic             clr,
    input  logic             load,
    output logic             is_digit,
    output logic [ACC_W-1:0] acc,
    output logic [ACC_W-1:0] acc_nxt
);

    logic [ACC_W-1:0] acc_q;

    // Digit detect and next accumulated value; for '0'..'9' the low nibble is byte-8'h30
    always_comb begin
        is_digit = is_ascii_digit(data);
        acc_nxt  = (acc_q << 3) + (acc_q << 1) + {{(ACC_W-4){1'b0}}, data[3:0]};
    end

    // Accumulator register; clear has priority over load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (load && is_digit) begin
            acc_q <= acc_nxt;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/servo_cmd_parser.sv
// Parses "#IIIPppppTtttt!" command frames from the UART byte stream.
module servo_cmd_parser
    import servo_pkg::*;
#(
    parameter int unsigned CLK_FRE    = 50,
    parameter int unsigned TIMEOUT_US = 2000,
    parameter int unsigned ID_W       = 8,
    parameter int unsigned ID_MAX     = 254,
    parameter int unsigned PWM_MIN    = 500,
    parameter int unsigned PWM_MAX    = 2500,
    parameter int unsigned TIME_W     = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_valid,
    output logic              cmd_valid,
    output logic [ID_W-1:0]   servo_id,
    output logic [11:0]       pwm_value,
    output logic [TIME_W-1:0] time_value,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              busy
);

    localparam int unsigned TO_CYC = CLK_FRE * TIMEOUT_US;
    localparam int unsigned TO_W   = $clog2(TO_CYC + 1);

    parser_state_e     state_q, state_d;
    logic [1:0]        dcnt_q, dcnt_d;
    logic [TO_W-1:0]   tmo_cnt_q;
    logic [9:0]        id_q, id_d;
    logic [ACC_W-1:0]  pwm_q, pwm_d;
    logic [ACC_W-1:0]  time_q, time_d;

    logic              cmd_valid_q, cmd_valid_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [ID_W-1:0]   servo_id_q, servo_id_d;
    logic [11:0]       pwm_value_q, pwm_value_d;
    logic [TIME_W-1:0] time_value_q, time_value_d;

    logic              acc_clr, acc_load, is_digit, bad_byte, range_ok, tmo_hit;
    logic [ACC_W-1:0]  acc, acc_nxt;

    servo_dec_acc u_dec_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .data     (rx_data),
        .clr      (acc_clr),
        .load     (acc_load),
        .is_digit (is_digit),
        .acc      (acc),
        .acc_nxt  (acc_nxt)
    );

    // Range check on the captured fields and timeout expiry detect
    always_comb begin
        range_ok = (id_q <= 10'(ID_MAX)) && (pwm_q >= ACC_W'(PWM_MIN))
                   && (pwm_q <= ACC_W'(PWM_MAX));
        tmo_hit  = (state_q != StHunt) && (tmo_cnt_q == TO_W'(TO_CYC - 1));
    end

    // Next-state, field capture and output pulse generation
    always_comb begin
        state_d      = state_q;
        dcnt_d       = dcnt_q;
        acc_clr      = 1'b0;
        acc_load     = 1'b0;
        bad_byte     = 1'b0;
        id_d         = id_q;
        pwm_d        = pwm_q;
        time_d       = time_q;
        cmd_valid_d  = 1'b0;
        err_d        = 1'b0;
        err_code_d   = ERR_NONE;
        servo_id_d   = servo_id_q;
        pwm_value_d  = pwm_value_q;
        time_value_d = time_value_q;

        if (rx_data_valid) begin
            unique case (state_q)
                StHunt: begin
                    if (rx_data == ASCII_HASH) begin
                        state_d = StId;
                        acc_clr = 1'b1;
                        dcnt_d  = 2'd0;
                    end
                end
                StId: begin
                    if (is_digit) begin
                        acc_load = 1'b1;
                        // Last digit: capture the value including this byte
                        if (dcnt_q == 2'(ID_LEN - 1)) begin
                            id_d    = 10'(acc_nxt);
                            acc_clr = 1'b1;
                            dcnt_d  = 2'd0;
                            state_d = StSepP;
                        end else begin
                            dcnt_d = dcnt_q + 2'd1;
                        end
                    end else begin
                        bad_byte = 1'b1;
                    end
                end
                StSepP: begin
                    if (rx_data == ASCII_P) state_d = StPwm;
                    else                    bad_byte = 1'b1;
                end
                StPwm: begin
                    if (is_digit) begin
                        acc_load = 1'b1;
                        if (dcnt_q == 2'(PWM_LEN - 1)) begin
                            pwm_d   = acc_nxt;
                            acc_clr = 1'b1;
                            dcnt_d  = 2'd0;
                            state_d = StSepT;
                        end else begin
                            dcnt_d = dcnt_q + 2'd1;
                        end
                    end else begin
                        bad_byte = 1'b1;
                    end
                end
                StSepT: begin
                    if (rx_data == ASCII_T) state_d = StTime;
                    else                    bad_byte = 1'b1;
                end
                StTime: begin
                    if (is_digit) begin
                        acc_load = 1'b1;
                        if (dcnt_q == 2'(TIME_LEN - 1)) begin
                            time_d  = acc_nxt;
                            acc_clr = 1'b1;
                            dcnt_d  = 2'd0;
                            state_d = StEnd;
                        end else begin
                            dcnt_d = dcnt_q + 2'd1;
                        end
                    end else begin
                        bad_byte = 1'b1;
                    end
                end
                StEnd: begin
                    if (rx_data == ASCII_BANG) begin
                        state_d = StHunt;
                        if (range_ok) begin
                            cmd_valid_d  = 1'b1;
                            servo_id_d   = ID_W'(id_q);
                            pwm_value_d  = 12'(pwm_q);
                            time_value_d = TIME_W'(time_q);
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = ERR_RANGE;
                        end
                    end else begin
                        bad_byte = 1'b1;
                    end
                end
                default: state_d = StHunt;
            endcase

            // A stray '#' aborts the frame but also starts a new one
            if (bad_byte) begin
                err_d      = 1'b1;
                err_code_d = ERR_SYNTAX;
                acc_clr    = 1'b1;
                dcnt_d     = 2'd0;
                state_d    = (rx_data == ASCII_HASH) ? StId : StHunt;
            end
        end else if (tmo_hit) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
            acc_clr    = 1'b1;
            dcnt_d     = 2'd0;
            state_d    = StHunt;
        end
    end

    // Inter-byte gap counter; only runs while a frame is open
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q == StHunt || rx_data_valid) begin
            tmo_cnt_q <= '0;
        end else if (!tmo_hit) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // State, captured fields and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StHunt;
            dcnt_q       <= 2'd0;
            id_q         <= '0;
            pwm_q        <= '0;
            time_q       <= '0;
            cmd_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            servo_id_q   <= '0;
            pwm_value_q  <= '0;
            time_value_q <= '0;
        end else begin
            state_q      <= state_d;
            dcnt_q       <= dcnt_d;
            id_q         <= id_d;
            pwm_q        <= pwm_d;
            time_q       <= time_d;
            cmd_valid_q  <= cmd_valid_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            servo_id_q   <= servo_id_d;
            pwm_value_q  <= pwm_value_d;
            time_value_q <= time_value_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign servo_id   = servo_id_q;
    assign pwm_value  = pwm_value_q;
    assign time_value = time_value_q;
    assign busy       = (state_q != StHunt);

endmodule
